bin_to_bcd4: RTL and testbench

BIN_TO_BCD4 -- requirements
Module: bin_to_bcd4

---
 rtl/bcd_pkg.sv | 39 +++
 rtl/bin_to_bcd4_if.sv | 34 +++
 rtl/bcd_add3.sv | 15 +
 rtl/bin_to_bcd4.sv | 134 +++++++++++++
 tb/tb_bin_to_bcd4.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the four-digit binary-to-BCD converter:
//   state_t      - converter FSM states (IDLE, SHIFT)
//   DIGIT_ERR    - digit code shown on every position when the value is too big
//   DIGIT_BLANK  - digit code that the display scanner renders as dark
//   DEFAULT_MAX  - largest value four decimal digits can show
//   apply_blank  - leading-zero blanking of a packed {d3,d2,d1,d0} BCD word
// ----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0]  DIGIT_ERR   = 4'he;
    localparam logic [3:0]  DIGIT_BLANK = 4'hf;
    localparam int unsigned DEFAULT_MAX = 9999;

    // Replace zeros above the most significant nonzero digit with the blank
    // code. The units digit is never touched, so zero still reads "0".
    function automatic logic [15:0] apply_blank(input logic [15:0] bcd,
                                                input logic        en);
        logic [15:0] r;
        r = bcd;
        if (en && bcd[15:12] == 4'd0) begin
            r[15:12] = DIGIT_BLANK;
            if (bcd[11:8] == 4'd0) begin
                r[11:8] = DIGIT_BLANK;
                if (bcd[7:4] == 4'd0) begin
                    r[7:4] = DIGIT_BLANK;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd4_if.sv
// ----------------------------------------------------------------------------
// bin_to_bcd4_if
// Request/result bundle of the binary-to-BCD converter.
//   start, bin, blank_lz   - conversion request (master -> slave)
//   busy, done, ovf        - status (slave -> master)
//   l0..l3                 - digit codes, l0 rightmost (slave -> master)
// The converter is the slave; whoever requests conversions is the master.
// ----------------------------------------------------------------------------
interface bin_to_bcd4_if #(
    parameter int WIDTH = 14
) ();

    logic             start;
    logic [WIDTH-1:0] bin;
    logic             blank_lz;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       l0;
    logic [3:0]       l1;
    logic [3:0]       l2;
    logic [3:0]       l3;

    modport master (
        output start, bin, blank_lz,
        input  busy, done, ovf, l0, l1, l2, l3
    );

    modport slave (
        input  start, bin, blank_lz,
        output busy, done, ovf, l0, l1, l2, l3
    );

endinterface

// File: rtl/bcd_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
//   d - scratch BCD digit before the shift
//   q - corrected digit
// ----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd4.sv
// ----------------------------------------------------------------------------
// bin_to_bcd4
// Sequential double-dabble converter from a WIDTH-bit unsigned value to four
// display digit codes, one shift step per clock.
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - bin_to_bcd4_if slave: start/bin/blank_lz in, busy/done/ovf/l0..l3
// A request is taken only in IDLE. The visible digits and ovf are held in an
// output buffer that changes only on the final shift edge, together with a
// one-cycle done pulse.
// ----------------------------------------------------------------------------
module bin_to_bcd4
    import bcd_pkg::*;
#(
    parameter int          WIDTH   = 14,
    parameter int unsigned MAX_VAL = DEFAULT_MAX
) (
    input logic          clk,
    input logic          rst,
    bin_to_bcd4_if.slave bus
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] bin_q;       // remaining binary bits, MSB shifts out
    logic [15:0]      bcd_q;       // scratch BCD digits {d3,d2,d1,d0}
    logic             blank_q;
    logic             ovf_pend_q;  // captured value above MAX_VAL
    logic             lost_q;      // a '1' was shifted out above d3
    logic             done_q;
    logic             ovf_q;
    logic [15:0]      disp_q;      // visible digits {l3,l2,l1,l0}

    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_next;
    logic             last_step;
    logic             ovf_final;

    for (genvar i = 0; i < 4; i++) begin : g_add3
        bcd_add3 u_add3 (
            .d (bcd_q[4*i +: 4]),
            .q (bcd_adj[4*i +: 4])
        );
    end

    assign bcd_next  = {bcd_adj[14:0], bin_q[WIDTH-1]};
    assign last_step = (state_q == SHIFT) && (cnt_q == LAST_STEP);
    // The thousands digit can only overflow for values of 10000 and up; treat
    // that as overflow too, so a MAX_VAL above 9999 cannot show wrong digits.
    assign ovf_final = ovf_pend_q | lost_q | bcd_adj[15];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop samples the
        // pre-edge values; blocking = here would create order-dependent races.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: capture, shift and output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the scratch and counter are reset as well as the outputs,
            // so an aborted conversion leaves nothing stale behind.
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            blank_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            lost_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bin_q      <= bus.bin;
                        blank_q    <= bus.blank_lz;
                        ovf_pend_q <= 32'(bus.bin) > MAX_VAL;
                        lost_q     <= 1'b0;
                        cnt_q      <= '0;
                        bcd_q      <= '0;
                    end
                end
                SHIFT: begin
                    bcd_q  <= bcd_next;
                    bin_q  <= bin_q << 1;
                    cnt_q  <= cnt_q + CW'(1);
                    lost_q <= lost_q | bcd_adj[15];
                    if (last_step) begin
                        done_q <= 1'b1;
                        ovf_q  <= ovf_final;
                        disp_q <= ovf_final ? {4{DIGIT_ERR}}
                                            : apply_blank(bcd_next, blank_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.l0   = disp_q[3:0];
    assign bus.l1   = disp_q[7:4];
    assign bus.l2   = disp_q[11:8];
    assign bus.l3   = disp_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd4.sv
// ----------------------------------------------------------------------------
// tb_bin_to_bcd4
// Self-checking bench for bin_to_bcd4. Every cycle of a conversion compares
// the packed observation {busy, done, ovf, l3, l2, l1, l0} against values
// computed from decimal arithmetic on the requested number.
// ----------------------------------------------------------------------------
module tb_bin_to_bcd4;

    localparam int WIDTH = 14;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    logic [16:0] cur;   // expected {ovf, l3, l2, l1, l0}

    bin_to_bcd4_if #(.WIDTH(WIDTH)) bus ();

    bin_to_bcd4 #(.WIDTH(WIDTH), .MAX_VAL(9999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Expected display for a value: plain decimal digits, error glyphs above
    // 9999, and blank codes on positions worth more than the value itself.
    function automatic logic [16:0] model(input int unsigned v, input bit blank);
        logic [16:0] r;
        int unsigned p;
        if (v > 9999) return {1'b1, 16'heeee};
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (blank && k > 0 && v < p) r[4*k +: 4] = 4'hf;
            else                         r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [18:0] observe();
        return {bus.busy, bus.done, bus.ovf, bus.l3, bus.l2, bus.l1, bus.l0};
    endfunction

    task automatic check(input string tag, input logic [18:0] obs,
                         input logic [18:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge, then scrambles bin/blank_lz so that a
    // design which does not capture them gives a wrong answer.
    task automatic start_conv(input int unsigned v, input bit blank);
        bus.start    = 1'b1;
        bus.bin      = WIDTH'(v);
        bus.blank_lz = blank;
        tick();
        bus.start    = 1'b0;
        bus.bin      = WIDTH'($urandom);
        bus.blank_lz = 1'($urandom);
    endtask

    // Follows a conversion from the cycle after the start edge to the done
    // cycle. glitch_at >= 0 raises start with another value mid-conversion.
    task automatic wait_done(input string tag, input int unsigned v,
                             input bit blank, input int glitch_at);
        for (int k = 0; k < WIDTH; k++) begin
            if (k == glitch_at) begin
                bus.start    = 1'b1;
                bus.bin      = WIDTH'(5678);
                bus.blank_lz = 1'b1;
            end else if (k == glitch_at + 1) begin
                bus.start = 1'b0;
            end
            check({tag, "_busy"}, observe(), {2'b10, cur});
            tick();
        end
        cur = model(v, blank);
        check({tag, "_done"}, observe(), {2'b01, cur});
    endtask

    task automatic convert(input string tag, input int unsigned v, input bit blank);
        start_conv(v, blank);
        wait_done(tag, v, blank, -1);
    endtask

    initial begin
        int unsigned v;
        bit          b;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.bin      = '0;
        bus.blank_lz = 1'b0;
        cur          = '0;
        tick();
        bus.start = 1'b1;   // reset wins over start
        tick();
        bus.start = 1'b0;
        check("reset", observe(), 19'd0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", observe(), 19'd0);

        // Plain conversion, then done must drop after one cycle.
        convert("d1234", 1234, 1'b0);
        tick();
        check("done_one_cycle", observe(), {2'b00, cur});

        convert("d9999", 9999, 1'b0);
        tick();
        convert("d10000", 10000, 1'b0);
        tick();
        convert("d0_blank", 0, 1'b1);
        tick();
        convert("d45_blank", 45, 1'b1);
        tick();
        convert("d0_noblank", 0, 1'b0);
        tick();
        convert("d16383", 16383, 1'b1);
        tick();

        // Start during a conversion is ignored; start in the done cycle is taken.
        start_conv(1234, 1'b0);
        wait_done("glitch1234", 1234, 1'b0, 5);
        convert("b2b5678", 5678, 1'b0);
        tick();
        check("b2b_idle", observe(), {2'b00, cur});

        // Reset at shift step 7 aborts the conversion without a done pulse.
        start_conv(4321, 1'b0);
        for (int k = 0; k < 7; k++) begin
            check("abort_busy", observe(), {2'b10, cur});
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur = '0;
        check("abort_reset", observe(), 19'd0);
        for (int k = 0; k < WIDTH + 2; k++) begin
            tick();
            check("abort_no_done", observe(), 19'd0);
        end
        convert("d4321_after_abort", 4321, 1'b0);
        tick();

        // Random values, with a bias toward small numbers for blanking, and
        // some conversions chained back-to-back from the done cycle.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 99);
            else                           v = $urandom_range(0, 16383);
            b = 1'($urandom);
            convert("rand", v, b);
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();
        check("final_idle", observe(), {2'b00, cur});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
